encrypt_ctrl: RTL and testbench

ENCRYPT_CTRL -- requirements
Module: encrypt_ctrl

---
 rtl/encrypt_pkg.sv | 19 +
 rtl/encrypt_subset_sum.sv | 25 ++
 rtl/encrypt_ctrl.sv | 137 +++++++++++++
 tb/tb_encrypt_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pkg.sv
// Purpose: shared FSM state encoding and default sizing for the encrypt datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_e (IDLE/FETCH/SUM/OUT) and DEF_* defaults for encrypt_ctrl / subset_sum.
package encrypt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SUM   = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int DEF_PLAINTEXT_WIDTH  = 6;
  localparam int DEF_CIPHERTEXT_WIDTH = 10;
  localparam int DEF_DIMENSION        = 1;
  localparam int DEF_BIG_N            = 30;

endpackage

// File: rtl/encrypt_subset_sum.sv
// Purpose: masked adder tree summing the selected words of one key row, mod 2^WORD_WIDTH.
// Latency: combinational (0 cycles).
// Backpressure: none; the caller holds words/mask stable while it needs the sum.
// Ports: words_i (NUM_WORDS packed words, word k at [k*WORD_WIDTH +: WORD_WIDTH]),
//        mask_i (bit k selects word k), sum_o (wrapping sum of selected words).
module subset_sum #(
  parameter int WORD_WIDTH = encrypt_pkg::DEF_CIPHERTEXT_WIDTH,
  parameter int NUM_WORDS  = encrypt_pkg::DEF_BIG_N
) (
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] words_i,
  input  logic [NUM_WORDS-1:0]            mask_i,
  output logic [WORD_WIDTH-1:0]           sum_o
);

  // Accumulating at WORD_WIDTH gives the modular wrap for free.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (mask_i[k]) begin
        sum_o = sum_o + words_i[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/encrypt_ctrl.sv
// Purpose: LWE-style encryption controller: fetch each public-key row, subset-sum it, emit one element per row.
// Latency: go accepted at t -> key_req at t+1 -> (key_valid at t+1) ct_valid at t+3; one SUM cycle per row.
// Backpressure: OUT holds ciphertext/ct_index/ct_last until ct_ready; FETCH holds key_req/addr until key_valid.
// Ports: clk, rst_n (sync, active-low); go/plaintext/noise_select (start + operands);
//        key_req/key_row_addr/key_valid/publickey_row (row fetch); ct_valid/ct_ready/ciphertext/ct_index/ct_last (output stream);
//        busy (high outside IDLE).
module encrypt_ctrl #(
  parameter int PLAINTEXT_WIDTH  = encrypt_pkg::DEF_PLAINTEXT_WIDTH,
  parameter int CIPHERTEXT_WIDTH = encrypt_pkg::DEF_CIPHERTEXT_WIDTH,
  parameter int DIMENSION        = encrypt_pkg::DEF_DIMENSION,
  parameter int BIG_N            = encrypt_pkg::DEF_BIG_N,
  localparam int ROW_WIDTH       = ($clog2(DIMENSION+1) > 1) ? $clog2(DIMENSION+1) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              go,
  input  logic [PLAINTEXT_WIDTH-1:0]        plaintext,
  input  logic [BIG_N-1:0]                  noise_select,
  output logic                              busy,
  output logic                              key_req,
  output logic [ROW_WIDTH-1:0]              key_row_addr,
  input  logic                              key_valid,
  input  logic [BIG_N*CIPHERTEXT_WIDTH-1:0] publickey_row,
  output logic                              ct_valid,
  input  logic                              ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]       ciphertext,
  output logic [ROW_WIDTH-1:0]              ct_index,
  output logic                              ct_last
);

  import encrypt_pkg::*;

  state_e                              state_q, state_d;
  logic [ROW_WIDTH-1:0]                row_q, row_d;
  logic [PLAINTEXT_WIDTH-1:0]          pt_q, pt_d;
  logic [BIG_N-1:0]                    mask_q, mask_d;
  logic [BIG_N*CIPHERTEXT_WIDTH-1:0]   words_q, words_d;
  logic [CIPHERTEXT_WIDTH-1:0]         ct_q, ct_d;

  logic [CIPHERTEXT_WIDTH-1:0]         row_sum;
  logic [CIPHERTEXT_WIDTH-1:0]         pt_ext;
  logic [CIPHERTEXT_WIDTH-1:0]         pt_scaled;
  logic                                is_b_row;

  // One adder tree shared by every row; it only ever sees the registered row.
  subset_sum #(
    .WORD_WIDTH (CIPHERTEXT_WIDTH),
    .NUM_WORDS  (BIG_N)
  ) u_subset_sum (
    .words_i (words_q),
    .mask_i  (mask_q),
    .sum_o   (row_sum)
  );

  // Message lives in the top PLAINTEXT_WIDTH bits of the ciphertext word.
  assign pt_ext    = CIPHERTEXT_WIDTH'(pt_q);
  assign pt_scaled = pt_ext << (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH);
  assign is_b_row  = (row_q == ROW_WIDTH'(DIMENSION));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      pt_q    <= '0;
      mask_q  <= '0;
      words_q <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pt_q    <= pt_d;
      mask_q  <= mask_d;
      words_q <= words_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    pt_d         = pt_q;
    mask_d       = mask_q;
    words_d      = words_q;
    ct_d         = ct_q;
    busy         = (state_q != IDLE);
    key_req      = 1'b0;
    key_row_addr = '0;
    ct_valid     = 1'b0;
    ciphertext   = '0;
    ct_index     = '0;
    ct_last      = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          pt_d    = plaintext;
          mask_d  = noise_select;
          row_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        key_req      = 1'b1;
        key_row_addr = row_q;
        if (key_valid) begin
          words_d = publickey_row;
          state_d = SUM;
        end
      end

      SUM: begin
        ct_d    = row_sum + (is_b_row ? pt_scaled : '0);
        state_d = OUT;
      end

      OUT: begin
        ct_valid   = 1'b1;
        ciphertext = ct_q;
        ct_index   = row_q;
        ct_last    = is_b_row;
        if (ct_ready) begin
          if (is_b_row) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d   = row_q + ROW_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Purpose: directed self-checking bench for encrypt_ctrl (BIG_N=4, DIMENSION=1, 6-bit pt, 10-bit ct).
// Latency: every check lands on a fixed cycle relative to go, so latency is checked implicitly.
// Backpressure: exercises ct_ready stalls and delayed key_valid.
module tb_encrypt_ctrl;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [5:0]  plaintext;
  logic [3:0]  noise_select;
  logic        busy;
  logic        key_req;
  logic [0:0]  key_row_addr;
  logic        key_valid;
  logic [39:0] publickey_row;
  logic        ct_valid;
  logic        ct_ready;
  logic [9:0]  ciphertext;
  logic [0:0]  ct_index;
  logic        ct_last;

  int tests = 0;
  int fails = 0;

  encrypt_ctrl #(
    .PLAINTEXT_WIDTH  (6),
    .CIPHERTEXT_WIDTH (10),
    .DIMENSION        (1),
    .BIG_N            (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .plaintext     (plaintext),
    .noise_select  (noise_select),
    .busy          (busy),
    .key_req       (key_req),
    .key_row_addr  (key_row_addr),
    .key_valid     (key_valid),
    .publickey_row (publickey_row),
    .ct_valid      (ct_valid),
    .ct_ready      (ct_ready),
    .ciphertext    (ciphertext),
    .ct_index      (ct_index),
    .ct_last       (ct_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] pack4(input int w0, input int w1, input int w2, input int w3);
    return {10'(w3), 10'(w2), 10'(w1), 10'(w0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  // go is always released here so it only ever lasts one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic start_op(input logic [5:0] pt, input logic [3:0] mask);
    go           = 1'b1;
    plaintext    = pt;
    noise_select = mask;
    step();
    // Scramble operands after acceptance; they must already be captured.
    plaintext    = ~pt;
    noise_select = ~mask;
  endtask

  // Entered with the DUT in FETCH. Serves one row, checks the element, completes the handshake.
  task automatic do_row(input string tag, input logic [0:0] exp_addr, input logic [39:0] data,
                        input int key_delay, input int ready_delay,
                        input logic [9:0] exp_ct, input logic exp_last);
    chk({tag, "_key_req"}, key_req, 1);
    chk({tag, "_addr"}, key_row_addr, exp_addr);
    for (int d = 0; d < key_delay; d++) begin
      key_valid = 1'b0;
      ct_ready  = 1'b1;  // no effect outside OUT
      step();
      chk({tag, "_key_req_hold"}, key_req, 1);
      chk({tag, "_addr_hold"}, key_row_addr, exp_addr);
      chk({tag, "_no_valid_wait"}, ct_valid, 0);
    end
    ct_ready      = 1'b0;
    key_valid     = 1'b1;
    publickey_row = data;
    step();
    key_valid     = 1'b0;
    publickey_row = '1;  // row must already be registered
    chk({tag, "_sum_no_valid"}, ct_valid, 0);
    chk({tag, "_sum_no_req"}, key_req, 0);
    step();
    chk({tag, "_valid"}, ct_valid, 1);
    chk({tag, "_ct"}, ciphertext, exp_ct);
    chk({tag, "_idx"}, ct_index, exp_addr);
    chk({tag, "_last"}, ct_last, exp_last);
    chk({tag, "_busy"}, busy, 1);
    for (int r = 0; r < ready_delay; r++) begin
      ct_ready      = 1'b0;
      key_valid     = 1'b1;  // no effect outside FETCH
      publickey_row = '1;
      step();
      chk({tag, "_bp_valid"}, ct_valid, 1);
      chk({tag, "_bp_ct"}, ciphertext, exp_ct);
      chk({tag, "_bp_idx"}, ct_index, exp_addr);
      chk({tag, "_bp_last"}, ct_last, exp_last);
      chk({tag, "_bp_no_req"}, key_req, 0);
    end
    key_valid = 1'b0;
    ct_ready  = 1'b1;
    step();
    ct_ready  = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_key_req"}, key_req, 0);
    chk({tag, "_ct_valid"}, ct_valid, 0);
    chk({tag, "_ct_last"}, ct_last, 0);
    chk({tag, "_addr"}, key_row_addr, 0);
    chk({tag, "_idx"}, ct_index, 0);
    chk({tag, "_ct"}, ciphertext, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    go            = 1'b0;
    plaintext     = '0;
    noise_select  = '0;
    key_valid     = 1'b0;
    publickey_row = '0;
    ct_ready      = 1'b0;
    repeat (2) step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // Basic: a = 1+3 = 4, b = 10+30 + 5<<4 = 120.
    start_op(6'd5, 4'b0101);
    do_row("basic0", 1'b0, pack4(1, 2, 3, 4), 0, 0, 10'd4, 1'b0);
    do_row("basic1", 1'b1, pack4(10, 20, 30, 40), 0, 0, 10'd120, 1'b1);
    chk("basic_done_busy", busy, 0);
    chk("basic_done_valid", ct_valid, 0);

    // Wrap: a = 1100 mod 1024 = 76, b = (4092 + 1008) mod 1024 = 1004.
    start_op(6'd63, 4'b1111);
    do_row("wrap0", 1'b0, pack4(100, 200, 300, 500), 0, 0, 10'd76, 1'b0);
    do_row("wrap1", 1'b1, pack4(1023, 1023, 1023, 1023), 0, 0, 10'd1004, 1'b1);

    // Backpressure: 5 stalled cycles on element 0 (7+8 = 15), then row 1 at addr 1 (100 + 16 = 116).
    start_op(6'd1, 4'b0011);
    do_row("bp0", 1'b0, pack4(7, 8, 9, 10), 0, 5, 10'd15, 1'b0);
    do_row("bp1", 1'b1, pack4(100, 0, 0, 0), 0, 0, 10'd116, 1'b1);

    // go while busy: second go with plaintext 50 in FETCH must be ignored (b = 3 + 2<<4 = 35).
    start_op(6'd2, 4'b1000);
    go        = 1'b1;
    plaintext = 6'd50;
    do_row("gob0", 1'b0, pack4(0, 0, 0, 9), 0, 0, 10'd9, 1'b0);
    chk("gob_mid_busy", busy, 1);
    do_row("gob1", 1'b1, pack4(0, 0, 0, 3), 0, 0, 10'd35, 1'b1);
    chk("gob_done_busy", busy, 0);

    // Reset for one cycle while in SUM aborts the operation.
    start_op(6'd5, 4'b0001);
    key_valid     = 1'b1;
    publickey_row = pack4(1, 2, 3, 4);
    step();
    key_valid     = 1'b0;
    chk("rst_in_sum", ct_valid, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_after_valid", ct_valid, 0);
      chk("rst_after_req", key_req, 0);
    end

    // All-zero mask: a = 0, b = 7<<4 = 112.
    start_op(6'd7, 4'b0000);
    do_row("zero0", 1'b0, pack4(5, 5, 5, 5), 0, 0, 10'd0, 1'b0);
    do_row("zero1", 1'b1, pack4(9, 9, 9, 9), 0, 0, 10'd112, 1'b1);

    // key_valid delayed 3 cycles: a = 2+3 = 5, b = 1+1 + 3<<4 = 50.
    start_op(6'd3, 4'b0110);
    do_row("kdel0", 1'b0, pack4(1, 2, 3, 4), 3, 0, 10'd5, 1'b0);
    do_row("kdel1", 1'b1, pack4(0, 1, 1, 0), 0, 0, 10'd50, 1'b1);
    chk("kdel_done_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
